// File: rtl/fixed_newton_unit_if.sv
// Operand/result handshake bundle for fixed_newton_unit.
// master drives operands and result acceptance; slave is the unit.
interface fixed_newton_unit_if #(
    parameter int W = 20
);
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_data;
    logic                in_mode;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_data;
    logic                out_err;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/fixed_newton_unit.sv
// Handshaked fixed-point 1/x and 1/sqrt(x): leading-one seed plus Newton steps.
// Define FIXED_NEWTON_SAT_EN for saturating arithmetic with error reporting.
module fixed_newton_unit #(
    parameter int W     = 20,
    parameter int F     = 8,
    parameter int NITER = 4
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    fixed_newton_unit_if.slave bus
);

    localparam int DW = 2 * W;
    localparam logic signed [W-1:0] MAX_POS    = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] TWO        = W'(2 << F);
    localparam logic signed [W-1:0] THREE_HALF = W'(3 << (F - 1));
    localparam logic [W-1:0]        ONE        = W'(1);
    localparam logic [3:0]          LAST       = 4'(NITER - 1);
`ifdef FIXED_NEWTON_SAT_EN
    localparam logic signed [W-1:0] MIN_NEG    = {1'b1, {(W-1){1'b0}}};
`endif

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        ITER_A,
        ITER_B,
        ITER_C,
        DONE
    } state_t;

    state_t               state;
    logic [W-1:0]         mag;
    logic                 mode;
    logic                 neg;
    logic signed [W-1:0]  opnd;
    logic signed [W-1:0]  y;
    logic signed [W-1:0]  t;
    logic [3:0]           cnt;
    logic                 idle_ready;
    logic                 res_valid;
    logic signed [W-1:0]  res_data;
    logic                 res_err;

    int                   lead;
    int                   expo;
    int                   sh;
    logic [W-1:0]         seed;
    logic signed [W-1:0]  cst;
    logic [W:0]           diff;
    logic signed [W-1:0]  corr;
    logic signed [W-1:0]  mul_a;
    logic signed [W-1:0]  mul_b;
    logic signed [DW-1:0] prod;
    logic signed [W-1:0]  mul_res;
    logic                 step_sat;
    logic                 unused_bits;

`ifdef FIXED_NEWTON_SAT_EN
    logic                 mul_ovf;
    logic                 sub_ovf;
    logic                 sat_seen;
`endif

    assign bus.in_ready  = idle_ready;
    assign bus.out_valid = res_valid;
    assign bus.out_data  = res_data;
    assign bus.out_err   = res_err;

    always_comb begin
        lead = 0;
        for (int i = 0; i < W; i++) begin
            if (mag[i]) lead = i;
        end
    end

    // Seeds are powers of two at or below the true result, so the
    // iterations approach from below and stay inside the format.
    always_comb begin
        expo = lead - F;
        if (mode) sh = F - ((expo + 2) >>> 1);
        else      sh = 2 * F - lead - 1;
        if (sh < 0)          sh = 0;
        else if (sh > W - 2) sh = W - 2;
        seed = ONE << sh;
    end

    always_comb begin
        cst  = mode ? THREE_HALF : TWO;
        diff = {cst[W-1], cst} - {t[W-1], t};
`ifdef FIXED_NEWTON_SAT_EN
        sub_ovf = diff[W] ^ diff[W-1];
        corr    = sub_ovf ? (diff[W] ? MIN_NEG : MAX_POS) : diff[W-1:0];
`else
        corr    = diff[W-1:0];
`endif
    end

    // One multiplier serves every phase; operands are steered by state.
    always_comb begin
        mul_a = opnd;
        mul_b = y;
        unique case (1'b1)
            state == ITER_B: mul_a = t;
            state == ITER_C: begin
                mul_a = y;
                mul_b = corr;
            end
            default: ;
        endcase
    end

    always_comb begin
        prod = DW'(mul_a) * DW'(mul_b);
`ifdef FIXED_NEWTON_SAT_EN
        mul_ovf = ~(&prod[DW-1:F+W-1]) & (|prod[DW-1:F+W-1]);
        mul_res = mul_ovf ? (prod[DW-1] ? MIN_NEG : MAX_POS) : prod[F +: W];
`else
        mul_res = prod[F +: W];
`endif
    end

`ifdef FIXED_NEWTON_SAT_EN
    assign step_sat = sat_seen | mul_ovf | sub_ovf;
`else
    assign step_sat = 1'b0;
`endif

    assign unused_bits = ^{prod[F-1:0], prod[DW-1:F+W], diff[W]};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= IDLE;
            mag        <= '0;
            mode       <= 1'b0;
            neg        <= 1'b0;
            opnd       <= '0;
            y          <= '0;
            t          <= '0;
            cnt        <= '0;
            idle_ready <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_err    <= 1'b0;
`ifdef FIXED_NEWTON_SAT_EN
            sat_seen   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    idle_ready <= 1'b1;
                    if (bus.in_valid && idle_ready) begin
                        mag <= bus.in_data[W-1] ? W'(-bus.in_data)
                                                : W'(bus.in_data);
                        mode       <= bus.in_mode;
                        neg        <= bus.in_data[W-1];
                        idle_ready <= 1'b0;
                        state      <= SEED;
                    end
                end
                SEED: begin
                    cnt <= '0;
`ifdef FIXED_NEWTON_SAT_EN
                    sat_seen <= 1'b0;
`endif
                    if (mag == '0) begin
                        res_data <= MAX_POS;
                        res_err  <= 1'b1;
                        state    <= DONE;
                    end else if (mode && neg) begin
                        res_data <= '0;
                        res_err  <= 1'b1;
                        state    <= DONE;
                    end else begin
                        y     <= seed;
                        opnd  <= mode ? W'(mag >> 1) : mag;
                        state <= ITER_A;
                    end
                end
                ITER_A: begin
                    t     <= mul_res;
                    state <= mode ? ITER_B : ITER_C;
`ifdef FIXED_NEWTON_SAT_EN
                    sat_seen <= sat_seen | mul_ovf;
`endif
                end
                ITER_B: begin
                    t     <= mul_res;
                    state <= ITER_C;
`ifdef FIXED_NEWTON_SAT_EN
                    sat_seen <= sat_seen | mul_ovf;
`endif
                end
                ITER_C: begin
                    y   <= mul_res;
                    cnt <= cnt + 4'd1;
`ifdef FIXED_NEWTON_SAT_EN
                    sat_seen <= step_sat;
`endif
                    if (cnt == LAST) begin
                        res_data  <= neg ? -mul_res : mul_res;
                        res_err   <= step_sat;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= ITER_A;
                    end
                end
                DONE: begin
                    // Special cases arrive here one cycle before valid rises.
                    if (!res_valid) begin
                        res_valid <= 1'b1;
                    end else if (bus.out_ready) begin
                        res_valid  <= 1'b0;
                        idle_ready <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_newton_unit.sv
// Self-checking bench for fixed_newton_unit (W=20, F=8, NITER=4).
// Results are compared with a real-valued 1/x and 1/sqrt(x) model.
module tb_fixed_newton_unit;

    localparam int W     = 20;
    localparam int F     = 8;
    localparam int NITER = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    fixed_newton_unit_if #(.W(W)) bus ();

    fixed_newton_unit #(.W(W), .F(F), .NITER(NITER)) dut (
        .clk_in  (clk),
        .rst_n_in(rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_near(input string tag, input int obs, input int exp,
                            input int tol);
        n_checks++;
        assert ((obs - exp) <= tol && (exp - obs) <= tol) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d +/- %0d",
                    tag, obs, exp, tol);
    endtask

    function automatic void ref_model(input int xv, input bit m,
                                      output int d, output bit e);
        real v;
        e = 1'b0;
        d = 0;
        if (xv == 0) begin
            d = (1 << (W - 1)) - 1;
            e = 1'b1;
        end else if (m && xv < 0) begin
            d = 0;
            e = 1'b1;
        end else begin
            v = real'(xv) / real'(1 << F);
            if (m) d = int'(real'(1 << F) / $sqrt(v));
            else   d = int'(real'(1 << F) / v);
        end
    endfunction

    task automatic offer(input logic [W-1:0] x, input bit m);
        int w;
        w = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = x;
        bus.in_mode  = m;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = W'($urandom);
        bus.in_mode  = 1'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (bus.out_valid !== 1'b1 && lat < 100);
    endtask

    task automatic take_result(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, " ready_after"}, 32'(bus.in_ready), 1);
        chk({tag, " valid_drop"}, 32'(bus.out_valid), 0);
    endtask

    task automatic run_chk(input string tag, input logic [W-1:0] x,
                           input bit m, input int exp_d, input int tol,
                           input bit exp_e, input int exp_lat);
        int lat;
        offer(x, m);
        wait_valid(lat);
        chk({tag, " latency"}, lat, exp_lat);
        chk_near({tag, " data"}, int'($signed(bus.out_data)), exp_d, tol);
        chk({tag, " err"}, 32'(bus.out_err), 32'(exp_e));
        take_result(tag);
    endtask

    initial begin
        logic [W-1:0] held;
        int           lat;
        int           rp_recip;
        int           rp_isqrt;
        n_checks      = 0;
        n_pass        = 0;
        rp_recip      = 1 + NITER * 2;
        rp_isqrt      = 1 + NITER * 3;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = 1'b0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst in_ready", 32'(bus.in_ready), 0);
        chk("rst out_valid", 32'(bus.out_valid), 0);
        chk("rst out_data", 32'(bus.out_data), 0);
        chk("rst out_err", 32'(bus.out_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle in_ready", 32'(bus.in_ready), 1);

        run_chk("recip 0.5", 20'h00080, 1'b0, 'h200, 2, 1'b0, rp_recip);
        run_chk("isqrt 4.0", 20'h00400, 1'b1, 'h080, 2, 1'b0, rp_isqrt);
        run_chk("isqrt 1.0", 20'h00100, 1'b1, 'h100, 2, 1'b0, rp_isqrt);
        run_chk("recip -2.0", 20'hFFE00, 1'b0, -'h80, 2, 1'b0, rp_recip);
        run_chk("isqrt neg", 20'hFFF00, 1'b1, 0, 0, 1'b1, 2);
        run_chk("recip zero", 20'h00000, 1'b0, 'h7FFFF, 0, 1'b1, 2);

        // Abort an inverse square root while it sits in its second phase.
        offer(20'h00400, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort in_ready", 32'(bus.in_ready), 0);
        chk("abort out_valid", 32'(bus.out_valid), 0);
        chk("abort out_data", 32'(bus.out_data), 0);
        chk("abort out_err", 32'(bus.out_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort release ready", 32'(bus.in_ready), 1);
        run_chk("recip 1.0 post", 20'h00100, 1'b0, 'h100, 2, 1'b0, rp_recip);

        // Backpressure: result must freeze while the consumer stalls.
        offer(20'h00180, 1'b0);
        wait_valid(lat);
        chk("bp latency", lat, rp_recip);
        held = bus.out_data;
        chk_near("bp data", int'($signed(held)), 171, 2);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.in_valid = (i == 2);
            bus.in_data  = 20'h00300;
            bus.in_mode  = 1'b1;
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            chk($sformatf("bp hold%0d data", i), 32'(bus.out_data), 32'(held));
            chk($sformatf("bp hold%0d in_ready", i), 32'(bus.in_ready), 0);
            chk($sformatf("bp hold%0d valid", i), 32'(bus.out_valid), 1);
        end
        take_result("bp release");
        run_chk("recip 4.0 after bp", 20'h00400, 1'b0, 'h40, 2, 1'b0, rp_recip);

        run_chk("recip tiny", 20'h00001, 1'b0, 'h10000, 4, 1'b0, rp_recip);
        chk("recip tiny sign", 32'(bus.out_data[W-1]), 0);

        for (int i = 0; i < 20; i++) begin
            bit m;
            int mag;
            int xv;
            int exp_d;
            bit exp_e;
            m = 1'($urandom_range(0, 1));
            if (!m) begin
                mag = int'($urandom_range(256, 65535));
                xv  = ($urandom_range(0, 1) == 1) ? -mag : mag;
            end else begin
                mag = int'($urandom_range(512, 65535));
                xv  = ($urandom_range(0, 7) == 0) ? -mag : mag;
            end
            ref_model(xv, m, exp_d, exp_e);
            run_chk($sformatf("rnd%0d x=%0d m=%0d", i, xv, m), W'(xv), m,
                    exp_d, exp_e ? 0 : 2, exp_e,
                    exp_e ? 2 : (m ? rp_isqrt : rp_recip));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
